wb_regfile: RTL

Write-back stage register file for the pipelined datapath. It is the consumer at the far end of the MEM/WB pipeline buffer: each cycle it takes that buffer's word, byte and control outputs plus the destination register index, and commits the result into a 2-read/1-write register file. The decode stage reads operands combinationally through two read ports, with same-cycle write-through bypass. It also keeps a retire counter and last-write status for debug and hazard logic.

---
 rtl/wb_regfile.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/wb_regfile.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// wb_regfile
//
// Write-back stage register file. Sits at the far end of the MEM/WB pipeline
// buffer and commits one result per cycle into a 2-read/1-write register
// file. Decode reads operands combinationally through two read ports. A write
// that commits this cycle is forwarded to a matching read port in the same
// cycle. A retire counter and last-write status are kept for debug and hazard
// logic.
//
// Parameters
//   S : MSB index of a data word (word width S+1, must be >= 8)
//   A : register address width (2**A registers)
//   C : MSB index of the write-back control field
//
// Ports
//   clk         in   clock, all state updates on the rising edge
//   rst         in   asynchronous active-low reset
//   InWord      in   word result from the MEM/WB buffer
//   InByte      in   byte result from the MEM/WB buffer
//   InCtrl      in   bit0 = write enable, bit1 = byte mode (1: InByte merge)
//   InDest      in   destination register index
//   RdAddrA/B   in   read port addresses
//   OutA/OutB   out  read port data (combinational, with write bypass)
//   WbValid     out  1 for the cycle after each committed write
//   LastDest    out  destination of the most recent committed write
//   LastData    out  value stored by the most recent committed write
//   RetireCount out  number of committed writes, wraps at 16 bits
// -----------------------------------------------------------------------------
module wb_regfile #(
  parameter int S = 15,
  parameter int A = 3,
  parameter int C = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [S:0]   InWord,
  input  logic [7:0]   InByte,
  input  logic [C:0]   InCtrl,
  input  logic [A-1:0] InDest,
  input  logic [A-1:0] RdAddrA,
  input  logic [A-1:0] RdAddrB,
  output logic [S:0]   OutA,
  output logic [S:0]   OutB,
  output logic         WbValid,
  output logic [A-1:0] LastDest,
  output logic [S:0]   LastData,
  output logic [15:0]  RetireCount
);

  localparam int NREG  = 2 ** A;
  localparam int NPORT = 2;

  // ---------------------------------------------------------------------------
  // Storage. Register 0 is not stored at all; it reads as a constant zero
  // through rd_view, so writes to it simply have nowhere to land.
  // ---------------------------------------------------------------------------
  logic [S:0]                mem_reg [1:NREG-1];
  logic [NREG-1:0][S:0]      rd_view;

  assign rd_view[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_view
      assign rd_view[gi] = mem_reg[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Commit decode and write value
  // ---------------------------------------------------------------------------
  logic             wr_en;
  logic             byte_mode;
  logic             commit;
  logic [S-8:0]     cur_hi;
  logic [S:0]       wr_val;
  logic [NREG-1:1]  we;

  assign wr_en     = InCtrl[0];
  assign byte_mode = InCtrl[1];

  // A write to register 0 is not a commit: it neither stores nor counts nor
  // touches the last-write status.
  assign commit = wr_en && (InDest != '0);

  // Byte mode keeps the upper part of the destination's current contents.
  // Reading through rd_view makes a byte write to r0 merge with zero, but
  // such a write never commits, so the value is irrelevant there.
  assign cur_hi = rd_view[InDest][S:8];
  assign wr_val = byte_mode ? {cur_hi, InByte} : InWord;

  // One-hot write enable per stored register.
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_we
      assign we[gi] = commit && (InDest == A'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NREG; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (we[i]) begin
          mem_reg[i] <= wr_val;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports. Each port resolves independently: address 0 reads zero, a
  // match against a pending commit forwards wr_val, otherwise stored data.
  // Forwarding is gated by rst so both ports read zero for the whole time
  // reset is held, even if the upstream buffer keeps presenting a write.
  // ---------------------------------------------------------------------------
  logic [NPORT-1:0][A-1:0] rd_addr;
  logic [NPORT-1:0][S:0]   rd_data;
  logic [NPORT-1:0]        bypass;

  assign rd_addr[0] = RdAddrA;
  assign rd_addr[1] = RdAddrB;

  generate
    for (gi = 0; gi < NPORT; gi++) begin : g_rd
      assign bypass[gi]  = rst && commit && (rd_addr[gi] == InDest);
      assign rd_data[gi] = (rd_addr[gi] == '0) ? '0 :
                           bypass[gi]          ? wr_val :
                                                 rd_view[rd_addr[gi]];
    end
  endgenerate

  assign OutA = rd_data[0];
  assign OutB = rd_data[1];

  // ---------------------------------------------------------------------------
  // Retire status
  // ---------------------------------------------------------------------------
  logic           wb_valid_reg;
  logic [A-1:0]   last_dest_reg;
  logic [S:0]     last_data_reg;
  logic [15:0]    retire_count_reg;
  logic [15:0]    retire_count_next;

  // Natural 16-bit wrap from FFFF to 0000.
  assign retire_count_next = retire_count_reg + 16'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid_reg     <= 1'b0;
      last_dest_reg    <= '0;
      last_data_reg    <= '0;
      retire_count_reg <= '0;
    end else begin
      // High exactly for the cycle after a commit; consecutive commits
      // keep it high.
      wb_valid_reg <= commit;
      if (commit) begin
        last_dest_reg    <= InDest;
        last_data_reg    <= wr_val;
        retire_count_reg <= retire_count_next;
      end
    end
  end

  assign WbValid     = wb_valid_reg;
  assign LastDest    = last_dest_reg;
  assign LastData    = last_data_reg;
  assign RetireCount = retire_count_reg;

endmodule
